// File: rtl/game_pkg.sv
// Shared digit format and answer-sequencer state encoding, used by the game FSM,
// the display logic and the answer sequencer.
package game_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] DIGIT_MIN = 4'd1;
  localparam logic [3:0] DIGIT_MAX = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_COMMIT = 3'd4
  } seq_state_e;

  // Three random bits map onto the digit range DIGIT_MIN..DIGIT_MAX.
  function automatic logic [DIGIT_W-1:0] rand_to_digit(input logic [2:0] i_bits);
    return {1'b0, i_bits} + DIGIT_MIN;
  endfunction

endpackage

// File: rtl/digit_dup_check.sv
// Parallel duplicate detector: compares one candidate digit against the first
// i_count entries of a packed staging vector within a single cycle.
module digit_dup_check
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [DIGIT_W-1:0]            i_digit,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_stage,
  input  logic [3:0]                    i_count,
  output logic                          o_is_dup
);

  logic [NUM_DIGITS-1:0] w_hit;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_cmp
    assign w_hit[g] = (4'(g) < i_count) && (i_stage[g*DIGIT_W +: DIGIT_W] == i_digit);
  end

  assign o_is_dup = |w_hit;

endmodule

// File: rtl/answer_sequencer.sv
// Draws NUM_DIGITS distinct digits from the LCG generator, retrying stalled
// draws and rejecting duplicates, then commits them as the new secret answer.
module answer_sequencer
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TIMEOUT    = 15,
  parameter int MAX_TRIES  = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [31:0]                   i_rng_rand,
  input  logic                          i_rng_we,
  output logic                          o_rng_req,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [NUM_DIGITS*DIGIT_W-1:0] o_answer,
  output logic [3:0]                    o_digit_count
);

  localparam int         ANS_W    = NUM_DIGITS * DIGIT_W;
  // Re-request lands exactly TIMEOUT cycles after the previous request.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 2);
  localparam logic [7:0] TRY_MAX  = 8'(MAX_TRIES);
  localparam logic [3:0] CNT_FULL = 4'(NUM_DIGITS);

  seq_state_e         r_state;
  seq_state_e         w_next;
  logic [7:0]         r_try;
  logic [7:0]         r_tmo;
  logic [DIGIT_W-1:0] r_digit;
  logic [ANS_W-1:0]   r_stage;
  logic [3:0]         r_count;
  logic               r_rng_req;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [ANS_W-1:0]   r_answer;

  logic               w_is_dup;
  logic               w_accept;
  logic [3:0]         w_count_after;
  logic [ANS_W-1:0]   w_stage_next;
  logic               w_start_acc;
  logic               w_tmo_hit;
  logic               w_try_max;
  logic               w_err_set;
  logic               w_req_d;
  logic               w_busy_d;
  logic               w_done_d;
  logic               w_unused_rand;

  assign w_unused_rand = ^i_rng_rand[31:3];

  digit_dup_check #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_dup (
    .i_digit  (r_digit),
    .i_stage  (r_stage),
    .i_count  (r_count),
    .o_is_dup (w_is_dup)
  );

  assign w_start_acc   = (r_state == ST_IDLE) && i_start;
  assign w_tmo_hit     = (r_tmo == TMO_LAST);
  assign w_try_max     = (r_try == TRY_MAX);
  assign w_accept      = (r_state == ST_CHECK) && !w_is_dup && (r_count < CNT_FULL);
  assign w_count_after = w_accept ? (r_count + 4'd1) : r_count;

  // Staging vector with the current candidate written at index r_count.
  always_comb begin
    w_stage_next = r_stage;
    if (w_accept) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_count == 4'(i)) begin
          w_stage_next[i*DIGIT_W +: DIGIT_W] = r_digit;
        end else begin
          w_stage_next[i*DIGIT_W +: DIGIT_W] = r_stage[i*DIGIT_W +: DIGIT_W];
        end
      end
    end else begin
      w_stage_next = r_stage;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next = ST_REQ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_rng_we) begin
          w_next = ST_CHECK;
        end else if (w_tmo_hit) begin
          if (w_try_max) begin
            w_next    = ST_IDLE;
            w_err_set = 1'b1;
          end else begin
            w_next = ST_REQ;
          end
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (w_count_after == CNT_FULL) begin
          w_next = ST_COMMIT;
        end else if (w_try_max) begin
          w_next    = ST_IDLE;
          w_err_set = 1'b1;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_COMMIT: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state; registered below.
  always_comb begin
    w_req_d  = 1'b0;
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    case (w_next)
      ST_REQ:    begin w_req_d = 1'b1; w_busy_d = 1'b1; end
      ST_WAIT:   begin w_busy_d = 1'b1; end
      ST_CHECK:  begin w_busy_d = 1'b1; end
      ST_COMMIT: begin w_done_d = 1'b1; end
      default:   begin w_busy_d = 1'b0; end
    endcase
  end

  // Counters, staging, digit latch and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_try     <= 8'd0;
      r_tmo     <= 8'd0;
      r_digit   <= 4'd0;
      r_stage   <= '0;
      r_count   <= 4'd0;
      r_rng_req <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_answer  <= '0;
    end else begin
      r_rng_req <= w_req_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;

      if (w_start_acc) begin
        r_error <= 1'b0;
      end else if (w_err_set) begin
        r_error <= 1'b1;
      end

      if (w_start_acc) begin
        r_count <= 4'd0;
        r_stage <= '0;
      end else if (r_state == ST_CHECK) begin
        r_count <= w_count_after;
        r_stage <= w_stage_next;
      end

      if (w_start_acc) begin
        r_try <= 8'd0;
      end else if ((r_state == ST_REQ) && (r_try != 8'hFF)) begin
        r_try <= r_try + 8'd1;
      end

      if (r_state == ST_REQ) begin
        r_tmo <= 8'd0;
      end else if ((r_state == ST_WAIT) && (r_tmo != 8'hFF)) begin
        r_tmo <= r_tmo + 8'd1;
      end

      if ((r_state == ST_WAIT) && i_rng_we) begin
        r_digit <= rand_to_digit(i_rng_rand[2:0]);
      end

      if (w_done_d) begin
        r_answer <= w_stage_next;
      end
    end
  end

  assign o_rng_req     = r_rng_req;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_answer      = r_answer;
  assign o_digit_count = r_count;

endmodule

// File: tb/tb_answer_sequencer.sv
// Bench for answer_sequencer: an event-scheduled model of the fill, plus a
// generator model that answers requests, drops some, and injects noise.
module tb_answer_sequencer;

  localparam int ND  = 4;
  localparam int TMO = 15;
  localparam int MT  = 8;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic          rng_we   = 1'b0;
  logic [31:0]   rng_rand = 32'd0;
  logic          rng_req, busy, done, error;
  logic [ND*4-1:0] answer;
  logic [3:0]    digit_count;

  always #5 clk = ~clk;

  answer_sequencer #(.NUM_DIGITS(ND), .TIMEOUT(TMO), .MAX_TRIES(MT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rng_rand(rng_rand),
    .i_rng_we(rng_we), .o_rng_req(rng_req), .o_busy(busy), .o_done(done),
    .o_error(error), .o_answer(answer), .o_digit_count(digit_count)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: cycle numbers at which the next fill events are due (-1 = none).
  bit          m_active = 1'b0;
  int          m_req_at = -1, m_done_at = -1, m_resp_at = -1;
  int          m_check_at = -1, m_deadline = -1, m_last_req = -1;
  int          m_tries = 0;
  logic [3:0]  m_digit = 4'd0;
  logic [3:0]  m_digits[$];
  logic [ND*4-1:0] m_answer = '0;
  bit          m_error = 1'b0;
  logic [31:0] m_resp_rand = 32'd0;

  bit          e_req = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [ND*4-1:0] e_ans = '0;
  logic [3:0]  e_cnt = 4'd0;

  int dq[$];
  bit drop_q[$];
  int drop_pct = 0;
  bit rand_delay = 1'b0;
  int req_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int req_times[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit s, input bit r);
    int k = cyc;
    bit drop;
    bit dup;
    int v;
    logic [31:0] rv;
    if (r) begin
      m_active = 1'b0; m_req_at = -1; m_done_at = -1; m_resp_at = -1;
      m_check_at = -1; m_deadline = -1; m_tries = 0;
      m_digits.delete(); m_answer = '0; m_error = 1'b0;
    end else if (s && !m_active && m_done_at != k) begin
      m_active = 1'b1; m_error = 1'b0; m_digits.delete(); m_tries = 0;
      m_req_at = k + 1;
    end else if (m_active && k == m_req_at) begin
      m_tries = (m_tries < 255) ? m_tries + 1 : m_tries;
      m_last_req = k;
      m_deadline = k + TMO - 1;
      if (drop_q.size() > 0) drop = drop_q.pop_front();
      else drop = ($urandom_range(0, 99) < drop_pct);
      if (!drop) begin
        rv = $urandom;
        if (dq.size() > 0) begin
          v = dq.pop_front();
          rv[2:0] = v[2:0];
        end
        m_resp_rand = rv;
        m_resp_at = k + (rand_delay ? int'($urandom_range(1, 4)) : 2);
      end
    end else if (m_active && k == m_resp_at) begin
      m_digit = {1'b0, m_resp_rand[2:0]} + 4'd1;
      m_check_at = k + 1; m_deadline = -1; m_resp_at = -1;
    end else if (m_active && k == m_deadline) begin
      m_deadline = -1;
      if (m_tries == MT) begin m_error = 1'b1; m_active = 1'b0; end
      else m_req_at = k + 1;
    end else if (m_active && k == m_check_at) begin
      m_check_at = -1;
      dup = 1'b0;
      foreach (m_digits[i]) if (m_digits[i] == m_digit) dup = 1'b1;
      if (!dup) m_digits.push_back(m_digit);
      if (m_digits.size() == ND) begin
        m_active = 1'b0; m_done_at = k + 1;
        for (int i = 0; i < ND; i++) m_answer[i*4 +: 4] = m_digits[i];
      end else if (m_tries == MT) begin
        m_error = 1'b1; m_active = 1'b0;
      end else begin
        m_req_at = k + 1;
      end
    end
    e_req  = m_active && (m_req_at == k + 1);
    e_done = (m_done_at == k + 1);
    e_busy = m_active;
    e_err  = m_error;
    e_ans  = m_answer;
    e_cnt  = 4'(m_digits.size());
  endtask

  // One clock cycle: drive inputs, advance the model, sample and compare.
  task automatic tick(input bit s, input bit r);
    start = s;
    rst = r;
    rng_we = 1'b0;
    rng_rand = $urandom;
    if (m_active && m_resp_at == cyc) begin
      rng_we = 1'b1;
      rng_rand = m_resp_rand;
    end else if (!m_active && $urandom_range(0, 7) == 0) begin
      rng_we = 1'b1;
    end
    model_step(s, r);
    @(posedge clk);
    #1;
    cyc++;
    chk("rng_req", 32'(rng_req), 32'(e_req));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(e_err));
    chk("answer", 32'(answer), 32'(e_ans));
    chk("digit_count", 32'(digit_count), 32'(e_cnt));
    if (rng_req === 1'b1) begin req_cnt++; req_times.push_back(cyc); end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic stats_clear();
    req_cnt = 0; done_cnt = 0; busy_cnt = 0;
    req_times.delete();
  endtask

  task automatic run_fill(input int budget);
    int n = 0;
    tick(1'b1, 1'b0);
    while (m_active && n < budget) begin
      tick(1'b0, 1'b0);
      n++;
    end
    n_cmp++;
    if (m_active) begin
      n_fail++;
      $display("FAIL fill_timeout cycle=%0d actual=still_busy required=finished", cyc);
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset held 3 cycles, then idle with no start.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("rst_answer", 32'(answer), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    stats_clear();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    chk("idle_no_req", 32'(req_cnt), 32'd0);

    // Straight fill, low bits 0..3.
    stats_clear();
    dq = '{0, 1, 2, 3};
    run_fill(200);
    chk("seq_answer", 32'(answer), 32'h4321);
    chk("seq_reqs", 32'(req_cnt), 32'd4);
    chk("seq_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("seq_done_pulses", 32'(done_cnt), 32'd1);
    chk("seq_error", 32'(error), 32'd0);

    // Duplicates rejected.
    stats_clear();
    dq = '{5, 5, 5, 2, 7, 0};
    run_fill(200);
    chk("dup_answer", 32'(answer), 32'h1836);
    chk("dup_reqs", 32'(req_cnt), 32'd6);
    chk("dup_count", 32'(digit_count), 32'd4);

    // Second response dropped -> timeout re-request.
    stats_clear();
    dq = '{0, 1, 2, 3};
    drop_q = '{1'b0, 1'b1};
    run_fill(300);
    chk("tmo_reqs", 32'(req_cnt), 32'd5);
    chk("tmo_gap", (req_times.size() > 2) ? 32'(req_times[2] - req_times[1]) : 32'hFFFF, 32'd15);
    chk("tmo_answer", 32'(answer), 32'h4321);

    // Always the same digit -> MAX_TRIES exhausted.
    stats_clear();
    dq = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_fill(300);
    chk("err_flag", 32'(error), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_reqs", 32'(req_cnt), 32'd8);
    chk("err_done", 32'(done_cnt), 32'd0);
    chk("err_answer_kept", 32'(answer), 32'h4321);
    tick(1'b1, 1'b0);
    chk("err_cleared", 32'(error), 32'd0);
    n = 0;
    while (m_active && n < 300) begin tick(1'b0, 1'b0); n++; end
    tick(1'b0, 1'b0);

    // Reset in WAIT after two accepted digits.
    stats_clear();
    dq = '{4, 5, 6};
    tick(1'b1, 1'b0);
    n = 0;
    while (!(m_digits.size() == 2 && cyc == m_last_req + 1) && n < 200) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("mid_reached_wait", 32'(digit_count), 32'd2);
    tick(1'b0, 1'b1);
    chk("mid_rst_answer", 32'(answer), 32'h0);
    chk("mid_rst_count", 32'(digit_count), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    dq.delete();
    stats_clear();
    dq = '{0, 1, 2, 3};
    run_fill(200);
    chk("mid_refill_done", 32'(done_cnt), 32'd1);
    chk("mid_refill_answer", 32'(answer), 32'h4321);
    chk("mid_refill_count", 32'(digit_count), 32'd4);

    // Randomized traffic: random data, drops, latencies, stray starts/resets.
    dq.delete();
    drop_q.delete();
    drop_pct = 10;
    rand_delay = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
